// File: rtl/widexnor_serializer.sv
// widexnor_serializer: MSB-first serializer of an activation/weight word pair for a bit-serial XNOR stage
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   in_valid   word pair offered on a_in/w_in
//   in_ready   word pair can be taken this cycle (idle, or on the last beat of a word)
//   a_in, w_in parallel activation/weight words (wide bits)
//   a, w       registered serial bits, MSB first, zero when out_valid is low
//   out_valid  a/w carry a beat this cycle
//   done       pulse on the last beat of a word
//   x_parity   only with WIDEXNOR_SER_PARITY_EN: XOR-reduction of ~(a_in ^ w_in), held for the word
// Optional feature macro: WIDEXNOR_SER_PARITY_EN
module widexnor_serializer #(
    parameter int wide = 72
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [wide-1:0] a_in,
    input  logic [wide-1:0] w_in,
    output logic            a,
    output logic            w,
    output logic            out_valid,
    output logic            done
`ifdef WIDEXNOR_SER_PARITY_EN
    ,
    output logic            x_parity
`endif
);
    localparam int cw = $clog2(wide);
    localparam logic [cw-1:0] last_beat = cw'(wide - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t            state_q, state_d;
    logic [cw-1:0]     cnt_q, cnt_d;
    logic [wide-1:0]   a_sr_q, a_sr_d;
    logic [wide-1:0]   w_sr_q, w_sr_d;
    logic              a_q, a_d;
    logic              w_q, w_d;
    logic              out_valid_q, out_valid_d;
    logic              done_q, done_d;
    logic              on_last;
    logic              xfer;

    assign on_last  = (state_q == SHIFT) && (cnt_q == last_beat);
    assign in_ready = (state_q == IDLE) || on_last;
    assign xfer     = in_valid && in_ready;

    // The shift registers hold the bits still to be sent, left-aligned; the
    // first bit goes straight into a_q/w_q on the capturing edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_sr_d      = a_sr_q;
        w_sr_d      = w_sr_q;
        a_d         = 1'b0;
        w_d         = 1'b0;
        out_valid_d = 1'b0;
        if (xfer) begin
            state_d     = SHIFT;
            cnt_d       = '0;
            a_sr_d      = {a_in[wide-2:0], 1'b0};
            w_sr_d      = {w_in[wide-2:0], 1'b0};
            a_d         = a_in[wide-1];
            w_d         = w_in[wide-1];
            out_valid_d = 1'b1;
        end else if (state_q == SHIFT && !on_last) begin
            cnt_d       = cnt_q + 1'b1;
            a_sr_d      = {a_sr_q[wide-2:0], 1'b0};
            w_sr_d      = {w_sr_q[wide-2:0], 1'b0};
            a_d         = a_sr_q[wide-1];
            w_d         = w_sr_q[wide-1];
            out_valid_d = 1'b1;
        end else begin
            state_d = IDLE;
            cnt_d   = '0;
        end
        done_d = out_valid_d && (cnt_d == last_beat);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q       <= '0;
            a_sr_q      <= '0;
            w_sr_q      <= '0;
            a_q         <= 1'b0;
            w_q         <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            a_sr_q      <= a_sr_d;
            w_sr_q      <= w_sr_d;
            a_q         <= a_d;
            w_q         <= w_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign a         = a_q;
    assign w         = w_q;
    assign out_valid = out_valid_q;
    assign done      = done_q;

`ifdef WIDEXNOR_SER_PARITY_EN
    logic x_parity_q, x_parity_d;

    always_comb x_parity_d = xfer ? ^(~(a_in ^ w_in)) : x_parity_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_parity_q <= 1'b0;
        end else begin
            x_parity_q <= x_parity_d;
        end
    end

    assign x_parity = x_parity_q;
`endif

endmodule

// File: tb/tb_widexnor_serializer.sv
// tb_widexnor_serializer: scoreboard bench for widexnor_serializer at wide=8 and wide=72
module tb_widexnor_serializer;
    typedef struct {
        logic [71:0] a;
        logic [71:0] w;
        int          t;
    } xfer_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    int          cyc = 0;

    logic        v8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  w8 = '0;
    logic        rdy8, ao8, wo8, ov8, dn8;
    logic        v72 = 1'b0;
    logic [71:0] a72 = '0;
    logic [71:0] w72 = '0;
    logic        rdy72, ao72, wo72, ov72, dn72;
`ifdef WIDEXNOR_SER_PARITY_EN
    logic        xp8, xp72;
`endif

    widexnor_serializer #(.wide(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(v8), .in_ready(rdy8),
        .a_in(a8), .w_in(w8), .a(ao8), .w(wo8), .out_valid(ov8), .done(dn8)
`ifdef WIDEXNOR_SER_PARITY_EN
        , .x_parity(xp8)
`endif
    );

    widexnor_serializer #(.wide(72)) dut72 (
        .clk(clk), .reset(reset), .in_valid(v72), .in_ready(rdy72),
        .a_in(a72), .w_in(w72), .a(ao72), .w(wo72), .out_valid(ov72), .done(dn72)
`ifdef WIDEXNOR_SER_PARITY_EN
        , .x_parity(xp72)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xfer_t       q0[$];
    xfer_t       q1[$];
    int          wd[2] = '{8, 72};
    int          last[2] = '{0, 0};
    logic        rdy_exp[2] = '{1'b1, 1'b1};
    int          beat[2] = '{0, 0};
    xfer_t       cur[2];
    logic [71:0] xs[2];
    int          n_tests = 0;
    int          n_fail = 0;
    logic        end_req = 1'b0;

    logic        nrst = 1'b0;
    logic        nv8 = 1'b0;
    logic [7:0]  na8 = '0;
    logic [7:0]  nw8 = '0;
    logic        nv72 = 1'b0;
    logic [71:0] na72 = '0;
    logic [71:0] nw72 = '0;
    logic        acc8 = 1'b0;

    task automatic chk(input string nm, input int d, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (wide=%0d, cycle %0d): got %0h, expected %0h", nm, wd[d], cyc, act, exp);
        end
    endtask

    task automatic mon(input int d, input logic ov, input logic ao, input logic wo,
                       input logic dn, input logic rdy
`ifdef WIDEXNOR_SER_PARITY_EN
                       , input logic px
`endif
                       );
        logic [71:0] mask;
        logic        exp_ov;
        int          front_t;
        mask = (72'd1 << wd[d]) - 72'd1;
        chk("in_ready", d, 72'(rdy), 72'(rdy_exp[d]));
        if (!reset) begin
            chk("reset_outputs", d, 72'({ov, ao, wo, dn}), 72'(0));
`ifdef WIDEXNOR_SER_PARITY_EN
            chk("reset_parity", d, 72'(px), 72'(0));
`endif
            beat[d] = 0;
        end else begin
            if (d == 0) front_t = q0.size() > 0 ? q0[0].t : -9;
            else        front_t = q1.size() > 0 ? q1[0].t : -9;
            exp_ov = (beat[d] != 0) || (front_t == cyc - 1);
            chk("out_valid", d, 72'(ov), 72'(exp_ov));
            if (!ov) begin
                chk("idle_bits", d, 72'({ao, wo, dn}), 72'(0));
            end else if (exp_ov) begin
                if (beat[d] == 0) begin
                    if (d == 0) cur[d] = q0.pop_front();
                    else        cur[d] = q1.pop_front();
                    xs[d] = '0;
                end
                chk("a_bit", d, 72'(ao), 72'(cur[d].a[wd[d]-1-beat[d]]));
                chk("w_bit", d, 72'(wo), 72'(cur[d].w[wd[d]-1-beat[d]]));
                chk("done", d, 72'(dn), 72'(beat[d] == wd[d] - 1));
`ifdef WIDEXNOR_SER_PARITY_EN
                chk("x_parity", d, 72'(px), 72'(^(~(cur[d].a ^ cur[d].w) & mask)));
`endif
                xs[d] = {xs[d][70:0], ~(ao ^ wo)};
                beat[d]++;
                if (beat[d] == wd[d]) begin
                    chk("xnor_word", d, xs[d] & mask, ~(cur[d].a ^ cur[d].w) & mask);
                    beat[d] = 0;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, ov8, ao8, wo8, dn8, rdy8
`ifdef WIDEXNOR_SER_PARITY_EN
            , xp8
`endif
            );
        mon(1, ov72, ao72, wo72, dn72, rdy72
`ifdef WIDEXNOR_SER_PARITY_EN
            , xp72
`endif
            );
        if (end_req) begin
            chk("drained", 0, 72'(q0.size() + beat[0]), 72'(0));
            chk("drained", 1, 72'(q1.size() + beat[1]), 72'(0));
        end
    end

    // One cycle of stimulus: apply the n* values just after the edge and record
    // in the reference model any word pair that the coming edge will accept.
    task automatic tick();
        xfer_t x;
        logic  acc72;
        @(posedge clk);
        #1;
        reset = nrst;
        if (!nrst) begin
            q0.delete();
            q1.delete();
            last[0] = cyc;
            last[1] = cyc;
        end
        v8 = nv8; a8 = na8; w8 = nw8;
        v72 = nv72; a72 = na72; w72 = nw72;
        rdy_exp[0] = cyc >= last[0];
        rdy_exp[1] = cyc >= last[1];
        acc8 = nrst && nv8 && rdy_exp[0];
        acc72 = nrst && nv72 && rdy_exp[1];
        if (acc8) begin
            x.a = 72'(na8); x.w = 72'(nw8); x.t = cyc;
            q0.push_back(x);
            last[0] = cyc + 8;
        end
        if (acc72) begin
            x.a = na72; x.w = nw72; x.t = cyc;
            q1.push_back(x);
            last[1] = cyc + 72;
        end
    endtask

    task automatic idle(input int n);
        nv8 = 1'b0;
        repeat (n) begin
            na8 = 8'($urandom);
            nw8 = 8'($urandom);
            tick();
        end
    endtask

    task automatic send8(input logic [7:0] av, input logic [7:0] wv);
        nv8 = 1'b1; na8 = av; nw8 = wv;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (acc8) break;
        end
        nv8 = 1'b0;
    endtask

    initial begin
        logic [95:0] r96;
        nrst = 1'b0;
        nv8 = 1'b1; na8 = 8'h5A; nw8 = 8'hC3;
        repeat (3) tick();
        nrst = 1'b1;
        idle(3);
        send8(8'hA5, 8'h3C);
        idle(12);
        send8(8'hFF, 8'h00);
        send8(8'h01, 8'h80);
        idle(12);
        send8(8'hA5, 8'h3C);
        idle(4);
        nrst = 1'b0;
        tick();
        tick();
        nrst = 1'b1;
        idle(2);
        send8(8'h3C, 8'hA5);
        idle(12);
        send8(8'hA5, 8'hA5);
        idle(10);
        send8(8'hA5, 8'hA4);
        idle(10);
        for (int i = 0; i < 15000; i++) begin
            nrst = (i != 7000);
            nv8 = $urandom_range(0, 3) != 0;
            na8 = 8'($urandom);
            nw8 = 8'($urandom);
            nv72 = $urandom_range(0, 7) != 0;
            r96 = {$urandom, $urandom, $urandom};
            na72 = r96[71:0];
            r96 = {$urandom, $urandom, $urandom};
            nw72 = r96[71:0];
            tick();
        end
        nrst = 1'b1;
        nv72 = 1'b0;
        idle(90);
        end_req = 1'b1;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
